// File: rtl/uart_pkg.sv
// Shared UART definitions for the 8N1 receiver and transmitter.
//   CLK_FREQ_DEFAULT / BAUD_DEFAULT : default system clock (Hz) and line rate (bit/s)
//   CNT_W                           : width of the bit-timing counter (CLKS_PER_BIT <= 8191)
//   clks_per_bit()                  : integer clocks per bit from clock and baud
//   rx_state_t                      : receiver FSM states, 2-bit encoding
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT = 50_000_000;
  localparam int unsigned BAUD_DEFAULT     = 115_200;
  localparam int unsigned CNT_W            = 13;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronised output
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle-high line. Each bit is sampled at its
// mid-point using the system clock as the oversampling clock.
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   rx           : serial input, asynchronous, idle high
//   rx_data      : last correctly framed byte, held until the next good frame
//   rx_valid     : 1-cycle pulse, rx_data updated this cycle
//   rx_frame_err : 1-cycle pulse, stop bit sampled low (rx_data not updated)
//   rx_busy      : high from start-edge detect until return to IDLE
// CLKS_PER_BIT = CLK_FREQ/BAUD must lie in 4..8191.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT,
  parameter int unsigned BAUD     = BAUD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_BIT - 1);

  logic             rx_s;
  logic             rx_s_d;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift_reg;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Edge register: a start needs rx_s to fall, so a line that is already low
  // (break, tail of a bad frame, or low at reset release) never starts a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_s_d <= 1'b1;
    else        rx_s_d <= rx_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s && rx_s_d) begin
            cnt     <= HALF_RELOAD;
            rx_busy <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              cnt   <= BIT_RELOAD;
              idx   <= '0;
              state <= DATA;
            end else begin
              // Start bit gone by mid-bit: treat as a glitch, no strobe.
              rx_busy <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shift_reg[idx] <= rx_s;
            cnt            <= BIT_RELOAD;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (rx_s) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
            // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
            rx_busy <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          rx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx, run at 14 clocks per bit (HALF_BIT = 7) so the
// full 256-byte loopback at +/-2% stays short.
module tb_uart_rx;

  localparam int unsigned CPB  = 14;
  localparam int unsigned HALF = 7;
  // Rx pin change at cycle k -> edge seen at k+3 -> stop sample at
  // k+3+7+9*14 = k+136; rx_valid is observed on that cycle.
  localparam int unsigned LAT  = 136;
  localparam int          TCLK = 100;
  localparam int          TBIT = 1400;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  int unsigned cycle = 0;
  int          valid_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  int unsigned err_cyc = 0;
  logic [7:0]  data_q[$];
  int unsigned vcyc_q[$];

  uart_rx #(.CLK_FREQ(1_400_000), .BAUD(100_000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #(TCLK/2) clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      data_q.push_back(rx_data);
      vcyc_q.push_back(cycle);
    end
    if (rx_frame_err) begin
      err_cnt++;
      err_cyc = cycle;
    end
    if (rx_valid && rx_frame_err) both_cnt++;
  end

  // Cycle-aligned frame; call just after a posedge, returns just after one.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            output int unsigned t0);
    rx = 1'b0;
    t0 = cycle;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Free-running transmitter with an arbitrary bit period (time units).
  task automatic send_async(input logic [7:0] b, input int period);
    rx = 1'b0;
    #(period);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(period);
    end
    rx = 1'b1;
    #(period);
  endtask

  function automatic logic [7:0] q_data(input int i);
    return (i < data_q.size()) ? data_q[i] : 8'hxx;
  endfunction

  function automatic int unsigned q_cyc(input int i);
    return (i < vcyc_q.size()) ? vcyc_q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_rx_frame_err got %b exp 0", rx_frame_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy got %b exp 0", rx_busy); end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    int v0, e0;
    int unsigned t0;
    data_q.delete(); vcyc_q.delete();
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b1, t0);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL single_valid_count got %0d exp 1", valid_cnt - v0); end
    checks++; if (q_data(0) !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", q_data(0)); end
    checks++; if (q_cyc(0) !== t0 + LAT) begin errors++; $display("FAIL single_latency got %0d exp %0d", q_cyc(0) - t0, LAT); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL single_frame_err got %0d exp 0", err_cnt - e0); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_data_held got %h exp a5", rx_data); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b exp 0", rx_busy); end
  endtask

  task automatic test_back_to_back;
    int v0, e0;
    int unsigned t0, t1;
    data_q.delete(); vcyc_q.delete();
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count got %0d exp 2", valid_cnt - v0); end
    checks++; if (q_data(0) !== 8'h00) begin errors++; $display("FAIL b2b_data0 got %h exp 00", q_data(0)); end
    checks++; if (q_data(1) !== 8'hFF) begin errors++; $display("FAIL b2b_data1 got %h exp ff", q_data(1)); end
    checks++; if (q_cyc(1) - q_cyc(0) !== 10 * CPB) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", q_cyc(1) - q_cyc(0), 10 * CPB); end
    checks++; if (q_cyc(1) !== t1 + LAT) begin errors++; $display("FAIL b2b_latency1 got %0d exp %0d", q_cyc(1) - t1, LAT); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL b2b_frame_err got %0d exp 0", err_cnt - e0); end
  endtask

  // Low pulse shorter than HALF_BIT: start sample sees high again.
  task automatic test_false_start;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL false_start_busy got %b exp 1", rx_busy); end
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL false_start_idle got %b exp 0", rx_busy); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL false_start_valid got %0d exp 0", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL false_start_err got %0d exp 0", err_cnt - e0); end
    checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL false_start_data got %h exp ff", rx_data); end
  endtask

  task automatic test_frame_err;
    int v0, e0;
    int unsigned t0, t1;
    data_q.delete(); vcyc_q.delete();
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0, t0);
    repeat (2 * CPB) @(posedge clk);
    #1;
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", err_cnt - e0); end
    checks++; if (err_cyc !== t0 + LAT) begin errors++; $display("FAIL ferr_latency got %0d exp %0d", err_cyc - t0, LAT); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL ferr_no_valid got %0d exp 0", valid_cnt - v0); end
    checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL ferr_data_held got %h exp ff", rx_data); end
    rx = 1'b1;
    repeat (CPB) @(posedge clk);
    #1;
    send_frame(8'h81, 1'b1, t1);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL ferr_recover_count got %0d exp 1", valid_cnt - v0); end
    checks++; if (q_data(0) !== 8'h81) begin errors++; $display("FAIL ferr_recover_data got %h exp 81", q_data(0)); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL ferr_total got %0d exp 1", err_cnt - e0); end
  endtask

  // 0xF0: bits 4..7 and stop are high, so nothing after reset release falls.
  task automatic test_reset_mid_frame;
    int v0, e0;
    int unsigned t0, t1;
    data_q.delete(); vcyc_q.delete();
    v0 = valid_cnt; e0 = err_cnt;
    fork
      send_frame(8'hF0, 1'b1, t0);
      begin
        repeat (72) @(posedge clk);
        #2;
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", rx_busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", rx_busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h exp 00", rx_data); end
        checks++; if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin errors++; $display("FAIL midrst_strobes got %b%b exp 00", rx_valid, rx_frame_err); end
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin errors++; $display("FAIL midrst_dropped got %0d/%0d exp 0/0", valid_cnt - v0, err_cnt - e0); end
    send_frame(8'h5A, 1'b1, t1);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL midrst_after_count got %0d exp 1", valid_cnt - v0); end
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL midrst_after_data got %h exp 5a", rx_data); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL midrst_after_err got %0d exp 0", err_cnt - e0); end
  endtask

  task automatic test_loopback(input int period);
    int v0, e0;
    data_q.delete(); vcyc_q.delete();
    v0 = valid_cnt; e0 = err_cnt;
    @(posedge clk);
    #37;
    for (int b = 0; b < 256; b++) send_async(8'(b), period);
    repeat (2 * CPB) @(posedge clk);
    #1;
    checks++; if (valid_cnt - v0 !== 256) begin errors++; $display("FAIL loop_%0d_count got %0d exp 256", period, valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL loop_%0d_frame_err got %0d exp 0", period, err_cnt - e0); end
    for (int b = 0; b < 256; b++) begin
      checks++;
      if (q_data(b) !== 8'(b)) begin
        errors++;
        $display("FAIL loop_%0d_byte%0d got %h exp %h", period, b, q_data(b), 8'(b));
      end
    end
  endtask

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_reset_mid_frame();
    test_loopback(TBIT * 102 / 100);
    test_loopback(TBIT * 98 / 100);
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL strobes_exclusive got %0d exp 0", both_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
